mprj_wb_arbiter: RTL and testbench
==================================

# mprj_wb_arbiter

Two-master Wishbone arbiter that shares the exported user-project bus (mprj_*) between the management core and a secondary master (SPI/debug bridge). Sits between the management core wrapper's exported Wishbone port and the user project area. Provides round-robin grant, in-order single-transaction ownership, and an optional bus-timeout watchdog that terminates hung user-project cycles.

## Interface
- TIMEOUT_CYCLES, 255: cycles of `stb` without `ack` before a forced termination; range 1..255, 8-bit counter.
- RESP_ON_TIMEOUT, 32'hFFFF_FFFF: read data returned on a forced termination.

Ports:
- core_clk  in  1  single clock for all logic.
- core_rstn  in  1  asynchronous active-low reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (management core) control.
- m0_sel_i  in  4; m0_adr_i, m0_dat_i  in  32  master 0 select/address/write data.
- m0_ack_o  out  1; m0_dat_o  out  32  master 0 acknowledge/read data.
- m1_*  same set as m0_*  master 1 (secondary).
- mprj_cyc_o, mprj_stb_o, mprj_we_o  out  1  to user project.
- mprj_sel_o  out  4; mprj_adr_o, mprj_dat_o  out  32.
- mprj_ack_i  in  1; mprj_dat_i  in  32  from user project.
- arb_grant  out  2  one-hot current owner (bit0 = m0, bit1 = m1); 2'b00 when idle.
- arb_timeout  out  1  one-cycle pulse on forced termination.

## Operation
- FSM states: IDLE, OWN0, OWN1, DRAIN.
- IDLE: m0_cyc only → OWN0; m1_cyc only → OWN1; both → the master not in `last_grant` wins. `last_grant` updates on entry to OWN0/OWN1.
- OWNx: mprj_cyc_o = mx_cyc_i, mprj_stb_o = mx_stb_i; we/sel/adr/dat muxed from mx. mx_ack_o = mprj_ack_i; mx_dat_o = mprj_dat_i. Non-owner: ack_o = 0, dat_o = 0, no stall signalling (it simply waits with cyc held).
- OWNx → IDLE when mx_cyc_i deasserts (sampled). Ownership spans the whole `cyc` burst; multiple stb/ack beats within one cyc stay with the owner.
- IDLE outputs: mprj_cyc_o = mprj_stb_o = mprj_we_o = 0; sel/adr/dat held at last value (don't-care).
- `ack` arriving while stb = 0 is ignored (not forwarded).
- Reset: state = IDLE, last_grant = m1 (so m0 wins the first tie), arb_grant = 0, arb_timeout = 0, all mprj control outputs 0, all mx_ack_o 0. Reset mid-transaction aborts immediately; no ack is issued.

## Timing
- Grant latency: cyc sampled high in IDLE → owner's signals on mprj_* the next cycle (1-cycle arbitration).
- Data path in OWNx is combinational: zero added latency for stb→mprj_stb and ack→mx_ack.
- Release: mx_cyc low at edge N → IDLE at N+1 → earliest new grant visible at N+2 (one dead cycle between owners).
- Simultaneous release by owner and request by other master: other master granted via the IDLE cycle, never directly OWN0→OWN1.
- With continuous requests from both, grants strictly alternate m0, m1, m0, …

## Configuration
- WB_ARB_TIMEOUT_EN defined: 8-bit counter clears on each ack or when stb = 0, increments while owner stb = 1 and ack = 0. On reaching TIMEOUT_CYCLES: same cycle, mx_ack_o = 1, mx_dat_o = RESP_ON_TIMEOUT, mprj_stb_o and mprj_cyc_o forced 0, arb_timeout = 1; FSM → DRAIN. DRAIN keeps mprj_cyc_o = 0, ignores mprj_ack_i, returns to IDLE when owner cyc drops.
- Not defined: no counter, no DRAIN state; arb_timeout tied 0; a hung slave holds the bus indefinitely.

## Test plan
- Single m0 read, slave acks after 3 cycles with 32'h1234_5678 → m0_ack_o pulses once with m0_dat_o = 32'h1234_5678; m1_ack_o stays 0; arb_grant = 2'b01 for the burst.
- m0 and m1 raise cyc in the same cycle out of reset → m0 granted first, m1 granted 2 cycles after m0 drops cyc; arb_grant 01 → 00 → 10.
- Both masters hold continuous 4-beat bursts for 6 bursts → grant order 0,1,0,1,0,1; no beat forwarded to the non-owner.
- core_rstn pulsed low while in OWN1 mid-stb → all mprj control outputs 0 asynchronously, arb_grant = 0; after release m0 wins the first tie.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, slave never acks → m0_ack_o asserted on 8th stb cycle with 32'hFFFF_FFFF, arb_timeout pulses once, a late mprj_ack_i in DRAIN is not forwarded.
- Without macro, same stimulus → no ack after 300 cycles, arb_timeout remains 0.

Source files
------------

// File: rtl/mprj_wb_arbiter.sv
// mprj_wb_arbiter
// Two-master Wishbone arbiter in front of the user-project bus (mprj_*).
// Master 0 is the management core, master 1 the secondary (SPI/debug) bridge.
// A master that raises cyc in IDLE owns the bus, one cycle later, for its
// whole cyc burst. Ties are broken round-robin against the last owner.
//
// Optional feature: define WB_ARB_TIMEOUT_EN to add a bus watchdog. After
// TIMEOUT_CYCLES cycles of owner stb without ack, the owner gets a forced ack
// with RESP_ON_TIMEOUT, the slave sees cyc/stb dropped, arb_timeout pulses,
// and the arbiter waits in a drain state until the owner drops cyc.
//
// Ports:
//   core_clk, core_rstn      clock, asynchronous active-low reset
//   m0_*, m1_*               Wishbone master ports (cyc/stb/we/sel/adr/dat in,
//                            ack/dat out)
//   mprj_*                   Wishbone port towards the user project
//   arb_grant                one-hot current owner (bit0 = m0, bit1 = m1)
//   arb_timeout              one-cycle pulse on a forced termination
module mprj_wb_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES  = 255,
   parameter logic [31:0] RESP_ON_TIMEOUT = 32'hFFFF_FFFF
) (
   input  logic        core_clk,
   input  logic        core_rstn,
   // master 0
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   output logic        m0_ack_o,
   output logic [31:0] m0_dat_o,
   // master 1
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   output logic        m1_ack_o,
   output logic [31:0] m1_dat_o,
   // user project
   output logic        mprj_cyc_o,
   output logic        mprj_stb_o,
   output logic        mprj_we_o,
   output logic [3:0]  mprj_sel_o,
   output logic [31:0] mprj_adr_o,
   output logic [31:0] mprj_dat_o,
   input  logic        mprj_ack_i,
   input  logic [31:0] mprj_dat_i,
   // status
   output logic [1:0]  arb_grant,
   output logic        arb_timeout
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must lie in 1..255");
   end

`ifdef WB_ARB_TIMEOUT_EN
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StOwn0  = 2'd1,
      StOwn1  = 2'd2,
      StDrain = 2'd3
   } state_e;

   localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);
`else
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StOwn0 = 2'd1,
      StOwn1 = 2'd2
   } state_e;
`endif

   state_e      state_q, state_d;
   logic        last_q, last_d;   // 1: m1 was granted last (also the owner in OWN/DRAIN)
   logic [1:0]  grant_q, grant_d;
   logic [3:0]  sel_q, sel_d;     // slave-side payload held while idle
   logic [31:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;

   logic        owning;
   logic        s_cyc, s_stb, s_we;
   logic [3:0]  s_sel;
   logic [31:0] s_adr, s_dat;
   logic        own_ack;
   logic [31:0] own_dat;

`ifdef WB_ARB_TIMEOUT_EN
   logic [7:0]  cnt_q, cnt_d;
   logic        timeout_hit;
`endif

   assign owning    = (state_q == StOwn0) || (state_q == StOwn1);
   assign arb_grant = grant_q;

   // Owner-side signal selection; last_q names the owner whenever one exists.
   always_comb begin
      if (last_q) begin
         s_cyc = m1_cyc_i;
         s_stb = m1_stb_i;
         s_we  = m1_we_i;
         s_sel = m1_sel_i;
         s_adr = m1_adr_i;
         s_dat = m1_dat_i;
      end else begin
         s_cyc = m0_cyc_i;
         s_stb = m0_stb_i;
         s_we  = m0_we_i;
         s_sel = m0_sel_i;
         s_adr = m0_adr_i;
         s_dat = m0_dat_i;
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   // Fires on the TIMEOUT_CYCLES-th consecutive stalled stb cycle.
   assign timeout_hit = owning && s_cyc && s_stb && !mprj_ack_i && (cnt_q == CntLast);
`endif

   // Bus-side outputs: combinational pass-through while owned.
   always_comb begin
      mprj_cyc_o  = 1'b0;
      mprj_stb_o  = 1'b0;
      mprj_we_o   = 1'b0;
      mprj_sel_o  = sel_q;
      mprj_adr_o  = adr_q;
      mprj_dat_o  = dat_q;
      m0_ack_o    = 1'b0;
      m1_ack_o    = 1'b0;
      m0_dat_o    = '0;
      m1_dat_o    = '0;
      arb_timeout = 1'b0;
      own_ack     = 1'b0;
      own_dat     = '0;
      sel_d       = sel_q;
      adr_d       = adr_q;
      dat_d       = dat_q;

      if (owning) begin
         mprj_cyc_o = s_cyc;
         mprj_stb_o = s_stb;
         mprj_we_o  = s_we;
         mprj_sel_o = s_sel;
         mprj_adr_o = s_adr;
         mprj_dat_o = s_dat;
         sel_d      = s_sel;
         adr_d      = s_adr;
         dat_d      = s_dat;
         // An ack without a pending stb is stray and must not reach the master.
         own_ack    = mprj_ack_i & s_stb;
         own_dat    = mprj_dat_i;
`ifdef WB_ARB_TIMEOUT_EN
         if (timeout_hit) begin
            mprj_cyc_o  = 1'b0;
            mprj_stb_o  = 1'b0;
            own_ack     = 1'b1;
            own_dat     = RESP_ON_TIMEOUT;
            arb_timeout = 1'b1;
         end
`endif
         if (last_q) begin
            m1_ack_o = own_ack;
            m1_dat_o = own_dat;
         end else begin
            m0_ack_o = own_ack;
            m0_dat_o = own_dat;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      grant_d = grant_q;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif

      unique case (state_q)
         StIdle: begin
`ifdef WB_ARB_TIMEOUT_EN
            cnt_d = '0;
`endif
            // m0 wins alone, or on a tie when m1 had the previous grant.
            if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
               state_d = StOwn0;
               last_d  = 1'b0;
               grant_d = 2'b01;
            end else if (m1_cyc_i) begin
               state_d = StOwn1;
               last_d  = 1'b1;
               grant_d = 2'b10;
            end
         end

         StOwn0, StOwn1: begin
            // Release always passes through IDLE so the other master is re-arbitrated.
            if (!s_cyc) begin
               state_d = StIdle;
               grant_d = 2'b00;
`ifdef WB_ARB_TIMEOUT_EN
               cnt_d   = '0;
            end else if (timeout_hit) begin
               state_d = StDrain;
               cnt_d   = '0;
            end else if (s_stb && !mprj_ack_i) begin
               cnt_d = cnt_q + 8'd1;
            end else begin
               cnt_d = '0;
`endif
            end
         end

`ifdef WB_ARB_TIMEOUT_EN
         StDrain: begin
            // Slave is cut off; wait for the owner to close its cycle.
            cnt_d = '0;
            if (!s_cyc) begin
               state_d = StIdle;
               grant_d = 2'b00;
            end
         end
`endif

         default: begin
            state_d = StIdle;
            grant_d = 2'b00;
         end
      endcase
   end

   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         state_q <= StIdle;
         last_q  <= 1'b1;
         grant_q <= 2'b00;
         sel_q   <= '0;
         adr_q   <= '0;
         dat_q   <= '0;
`ifdef WB_ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
`ifdef WB_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_mprj_wb_arbiter.sv
// Bench for mprj_wb_arbiter: directed master/slave stimulus, an owner-based
// reference model checked every cycle, and literal expectations per scenario.
module tb_mprj_wb_arbiter;

   localparam int          TO   = 8;
   localparam logic [31:0] RESP = 32'hFFFF_FFFF;
`ifdef WB_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk;
   logic        rstn;
   logic        m_cyc [2];
   logic        m_stb [2];
   logic        m_we  [2];
   logic [3:0]  m_sel [2];
   logic [31:0] m_adr [2];
   logic [31:0] m_wdat[2];
   logic        m0_ack, m1_ack;
   logic [31:0] m0_rdat, m1_rdat;
   logic        mprj_cyc, mprj_stb, mprj_we;
   logic [3:0]  mprj_sel;
   logic [31:0] mprj_adr, mprj_wdat;
   logic        mprj_ack;
   logic [31:0] slv_rdata;
   logic [1:0]  arb_grant;
   logic        arb_timeout;

   logic        slv_ack;
   logic        late_ack;
   int          slv_lat;
   int          wcnt;

   int          checks;
   int          passes;

   assign mprj_ack = slv_ack | late_ack;

   mprj_wb_arbiter #(
      .TIMEOUT_CYCLES (TO),
      .RESP_ON_TIMEOUT(RESP)
   ) dut (
      .core_clk   (clk),
      .core_rstn  (rstn),
      .m0_cyc_i   (m_cyc[0]),
      .m0_stb_i   (m_stb[0]),
      .m0_we_i    (m_we[0]),
      .m0_sel_i   (m_sel[0]),
      .m0_adr_i   (m_adr[0]),
      .m0_dat_i   (m_wdat[0]),
      .m0_ack_o   (m0_ack),
      .m0_dat_o   (m0_rdat),
      .m1_cyc_i   (m_cyc[1]),
      .m1_stb_i   (m_stb[1]),
      .m1_we_i    (m_we[1]),
      .m1_sel_i   (m_sel[1]),
      .m1_adr_i   (m_adr[1]),
      .m1_dat_i   (m_wdat[1]),
      .m1_ack_o   (m1_ack),
      .m1_dat_o   (m1_rdat),
      .mprj_cyc_o (mprj_cyc),
      .mprj_stb_o (mprj_stb),
      .mprj_we_o  (mprj_we),
      .mprj_sel_o (mprj_sel),
      .mprj_adr_o (mprj_adr),
      .mprj_dat_o (mprj_wdat),
      .mprj_ack_i (mprj_ack),
      .mprj_dat_i (slv_rdata),
      .arb_grant  (arb_grant),
      .arb_timeout(arb_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      else passes++;
   endtask

   function automatic logic ack_of(input int m);
      return (m == 0) ? m0_ack : m1_ack;
   endfunction

   // Slave: acks a pending stb slv_lat cycles after it appears.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         slv_ack <= 1'b0;
         wcnt    <= 0;
      end else if (mprj_stb && !slv_ack) begin
         if (wcnt >= slv_lat - 1) begin
            slv_ack <= 1'b1;
            wcnt    <= 0;
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         slv_ack <= 1'b0;
         wcnt    <= 0;
      end
   end

   // ---------------- reference model ----------------
   // Owner: 0 none, 1 m0, 2 m1. Last: previous owner (2 out of reset).
   int mo_owner = 0;
   int mo_last  = 2;
   bit mo_drain = 1'b0;
   int mo_stalls = 0;
   int mo_k;
   bit mo_t;

   function automatic bit mo_to();
      int k;
      if (!TO_EN || mo_owner == 0 || mo_drain) return 1'b0;
      k = mo_owner - 1;
      return m_cyc[k] && m_stb[k] && !mprj_ack && (mo_stalls + 1 >= TO);
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mo_owner  = 0;
         mo_last   = 2;
         mo_drain  = 1'b0;
         mo_stalls = 0;
      end else if (mo_owner == 0) begin
         if (m_cyc[0] && m_cyc[1]) mo_owner = (mo_last == 2) ? 1 : 2;
         else if (m_cyc[0])        mo_owner = 1;
         else if (m_cyc[1])        mo_owner = 2;
         if (mo_owner != 0) mo_last = mo_owner;
         mo_stalls = 0;
      end else begin
         mo_k = mo_owner - 1;
         mo_t = mo_to();
         if (!m_cyc[mo_k]) begin
            mo_owner  = 0;
            mo_drain  = 1'b0;
            mo_stalls = 0;
         end else if (mo_drain) begin
            mo_stalls = 0;
         end else if (mo_t) begin
            mo_drain  = 1'b1;
            mo_stalls = 0;
         end else if (m_stb[mo_k] && !mprj_ack) begin
            mo_stalls++;
         end else begin
            mo_stalls = 0;
         end
      end
   end

   // Per-cycle compare against the model.
   logic        e_cyc, e_stb, e_we, e_ack0, e_ack1, e_to, e_ack;
   logic [31:0] e_d0, e_d1, e_d;
   logic [1:0]  e_grant;
   int          ck;
   bit          ct;

   always @(negedge clk) begin
      e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_to = 1'b0;
      e_ack0 = 1'b0; e_ack1 = 1'b0; e_d0 = '0; e_d1 = '0; e_grant = 2'b00;
      if (mo_owner != 0) begin
         ck = mo_owner - 1;
         e_grant = (mo_owner == 1) ? 2'b01 : 2'b10;
         if (!mo_drain) begin
            ct    = mo_to();
            e_cyc = m_cyc[ck] && !ct;
            e_stb = m_stb[ck] && !ct;
            e_we  = m_we[ck];
            e_to  = ct;
            e_ack = ct ? 1'b1 : (mprj_ack && m_stb[ck]);
            e_d   = ct ? RESP : slv_rdata;
            if (ck == 0) begin e_ack0 = e_ack; e_d0 = e_d; end
            else         begin e_ack1 = e_ack; e_d1 = e_d; end
            chk("mprj_adr", mprj_adr, m_adr[ck]);
            chk("mprj_sel", 32'(mprj_sel), 32'(m_sel[ck]));
            chk("mprj_dat", mprj_wdat, m_wdat[ck]);
         end
      end
      chk("mprj_cyc", 32'(mprj_cyc), 32'(e_cyc));
      chk("mprj_stb", 32'(mprj_stb), 32'(e_stb));
      chk("mprj_we", 32'(mprj_we), 32'(e_we));
      chk("m0_ack", 32'(m0_ack), 32'(e_ack0));
      chk("m1_ack", 32'(m1_ack), 32'(e_ack1));
      chk("m0_dat", m0_rdat, e_d0);
      chk("m1_dat", m1_rdat, e_d1);
      chk("arb_grant", 32'(arb_grant), 32'(e_grant));
      chk("arb_timeout", 32'(arb_timeout), 32'(e_to));
   end

   // ---------------- monitors ----------------
   int          cyc_n = 0;
   logic [1:0]  glog_v[$];
   int          glog_t[$];
   logic [1:0]  prev_g = 2'b00;
   logic        prev_c0 = 1'b0;
   int          drop0_t = 0;
   int          ack0_n, ack1_n, to_n;
   logic [31:0] ack0_last;

   always @(posedge clk) cyc_n++;

   always @(negedge clk) begin
      if (arb_grant != prev_g) begin
         glog_v.push_back(arb_grant);
         glog_t.push_back(cyc_n);
      end
      prev_g = arb_grant;
      if (prev_c0 && !m_cyc[0]) drop0_t = cyc_n;
      prev_c0 = m_cyc[0];
      if (m0_ack) begin ack0_n++; ack0_last = m0_rdat; end
      if (m1_ack) ack1_n++;
      if (arb_timeout) to_n++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic clear_logs();
      glog_v.delete();
      glog_t.delete();
      ack0_n = 0;
      ack1_n = 0;
      to_n   = 0;
   endtask

   task automatic reset_dut();
      @(posedge clk); #1;
      rstn = 1'b0;
      late_ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      clear_logs();
   endtask

   task automatic burst(input int m, input int beats, input logic [31:0] base);
      int n;
      @(posedge clk); #1;
      m_cyc[m]  = 1'b1;
      m_stb[m]  = 1'b1;
      m_we[m]   = 1'(m);
      m_sel[m]  = (m == 0) ? 4'hF : 4'h3;
      m_adr[m]  = base;
      m_wdat[m] = base ^ 32'hA5A5_0000;
      for (int b = 0; b < beats; b++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!ack_of(m) && n < 500);
         if (!ack_of(m)) begin
            checks++;
            $display("FAIL burst_ack_wait m%0d: no ack after %0d cycles, expected ack", m, n);
         end
         @(posedge clk); #1;
         if (b == beats - 1) begin
            m_cyc[m] = 1'b0;
            m_stb[m] = 1'b0;
         end else begin
            m_adr[m]  = m_adr[m] + 32'd4;
            m_wdat[m] = m_wdat[m] + 32'd1;
         end
      end
   endtask

   logic [1:0] nz[$];
   int         n;

   initial begin
      checks = 0; passes = 0;
      rstn = 1'b0; late_ack = 1'b0; slv_lat = 1; slv_rdata = 32'h0;
      for (int i = 0; i < 2; i++) begin
         m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
         m_sel[i] = 4'h0; m_adr[i] = 32'h0; m_wdat[i] = 32'h0;
      end
      clear_logs();
      #2;
      chk("reset_grant", 32'(arb_grant), 32'h0);
      chk("reset_cyc", 32'(mprj_cyc), 32'h0);
      chk("reset_timeout", 32'(arb_timeout), 32'h0);
      reset_dut();

      // 1: single m0 read
      slv_lat = 3; slv_rdata = 32'h1234_5678;
      burst(0, 1, 32'h3000_0010);
      repeat (2) @(posedge clk);
      chk("t1_ack0_count", 32'(ack0_n), 32'd1);
      chk("t1_ack0_data", ack0_last, 32'h1234_5678);
      chk("t1_ack1_count", 32'(ack1_n), 32'd0);
      chk("t1_grant_log_len", 32'(glog_v.size()), 32'd2);
      if (glog_v.size() == 2) begin
         chk("t1_grant_first", 32'(glog_v[0]), 32'h1);
         chk("t1_grant_after", 32'(glog_v[1]), 32'h0);
      end

      // 2: simultaneous request out of reset
      reset_dut();
      slv_lat = 1; slv_rdata = 32'hCAFE_0001;
      fork
         burst(0, 2, 32'h3000_0100);
         burst(1, 2, 32'h3000_0200);
      join
      repeat (2) @(posedge clk);
      chk("t2_grant_log_len", 32'(glog_v.size()), 32'd4);
      if (glog_v.size() == 4) begin
         chk("t2_grant0", 32'(glog_v[0]), 32'h1);
         chk("t2_grant1", 32'(glog_v[1]), 32'h0);
         chk("t2_grant2", 32'(glog_v[2]), 32'h2);
         chk("t2_idle_after_drop", 32'(glog_t[1] - drop0_t), 32'd1);
         chk("t2_m1_after_drop", 32'(glog_t[2] - drop0_t), 32'd2);
      end

      // 3: continuous competing bursts alternate
      reset_dut();
      slv_lat = 1; slv_rdata = 32'h0BAD_F00D;
      fork
         begin
            for (int i = 0; i < 3; i++) burst(0, 4, 32'h3000_1000 + 32'(i) * 32'h40);
         end
         begin
            for (int i = 0; i < 3; i++) burst(1, 4, 32'h3000_2000 + 32'(i) * 32'h40);
         end
      join
      repeat (2) @(posedge clk);
      nz.delete();
      foreach (glog_v[i]) if (glog_v[i] != 2'b00) nz.push_back(glog_v[i]);
      chk("t3_grant_count", 32'(nz.size()), 32'd6);
      if (nz.size() == 6) begin
         for (int i = 0; i < 6; i++)
            chk($sformatf("t3_grant_order[%0d]", i), 32'(nz[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
      end
      chk("t3_ack0_count", 32'(ack0_n), 32'd12);
      chk("t3_ack1_count", 32'(ack1_n), 32'd12);

      // 4: asynchronous reset while m1 owns mid-stb
      reset_dut();
      slv_lat = 50;
      @(posedge clk); #1;
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
      m_adr[1] = 32'h3000_3000; m_sel[1] = 4'hF; m_wdat[1] = 32'h1111_2222;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("t4_m1_owns", 32'(arb_grant), 32'h2);
      chk("t4_stb_before", 32'(mprj_stb), 32'h1);
      #2 rstn = 1'b0;
      #1;
      chk("t4_rst_cyc", 32'(mprj_cyc), 32'h0);
      chk("t4_rst_stb", 32'(mprj_stb), 32'h0);
      chk("t4_rst_we", 32'(mprj_we), 32'h0);
      chk("t4_rst_grant", 32'(arb_grant), 32'h0);
      chk("t4_rst_ack1", 32'(m1_ack), 32'h0);
      @(posedge clk); #1;
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0;
      m_adr[0] = 32'h3000_4000; m_sel[0] = 4'hF; m_wdat[0] = 32'h0;
      @(posedge clk); #1 rstn = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t4_m0_wins_tie", 32'(arb_grant), 32'h1);
      @(posedge clk); #1;
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
      repeat (3) @(posedge clk);

      // 5: hung slave
      reset_dut();
      slv_lat = 100000; slv_rdata = 32'h5555_AAAA;
      @(posedge clk); #1;
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0;
      m_adr[0] = 32'h3000_5000; m_sel[0] = 4'hF;
`ifdef WB_ARB_TIMEOUT_EN
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (arb_grant == 2'b01 && m_stb[0]) n++;
         if (m0_ack) break;
      end
      chk("t5_ack_on_stb_cycle", 32'(n), 32'd8);
      chk("t5_ack", 32'(m0_ack), 32'h1);
      chk("t5_resp", m0_rdat, 32'hFFFF_FFFF);
      chk("t5_timeout_pulse", 32'(arb_timeout), 32'h1);
      @(posedge clk); #1;
      m_stb[0] = 1'b0; late_ack = 1'b1;
      @(negedge clk);
      chk("t5_late_ack_blocked", 32'(m0_ack), 32'h0);
      chk("t5_drain_cyc", 32'(mprj_cyc), 32'h0);
      @(posedge clk); #1;
      late_ack = 1'b0; m_cyc[0] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("t5_idle_grant", 32'(arb_grant), 32'h0);
      chk("t5_timeout_count", 32'(to_n), 32'd1);
      chk("t5_ack_count", 32'(ack0_n), 32'd1);
`else
      repeat (300) @(negedge clk);
      chk("t5_no_ack", 32'(ack0_n), 32'd0);
      chk("t5_no_timeout", 32'(to_n), 32'd0);
      chk("t5_still_owned", 32'(arb_grant), 32'h1);
      chk("t5_stb_held", 32'(mprj_stb), 32'h1);
`endif
      reset_dut();
      repeat (2) @(posedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
